// File: rtl/draw_layer_arbiter.sv
// Per-pixel draw arbiter: picks one winner per pixel from a double-buffered
// layer table, with per-object visibility, frame-rate blinking and overlap flags.
module draw_layer_arbiter #(
  parameter int NUM_OBJ  = 4,
  parameter int OFFSET_W = 11,
  parameter int BLINK_W  = 5,
  parameter int ID_W     = $clog2(NUM_OBJ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic [NUM_OBJ-1:0]           drawRequest,
  input  logic [NUM_OBJ*OFFSET_W-1:0]  offsetX,
  input  logic [NUM_OBJ*OFFSET_W-1:0]  offsetY,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ID_W-1:0]              cfg_obj,
  input  logic [ID_W-1:0]              cfg_layer,
  input  logic                         cfg_visible,
  input  logic                         cfg_blink,
  output logic [OFFSET_W-1:0]          offset_x,
  output logic [OFFSET_W-1:0]          offset_y,
  output logic                         drawRequestOut,
  output logic [ID_W-1:0]              winner_id,
  output logic                         collision,
  output logic                         collision_last_frame
);

  logic [ID_W-1:0]     sh_layer_q  [NUM_OBJ];
  logic [ID_W-1:0]     sh_layer_d  [NUM_OBJ];
  logic [NUM_OBJ-1:0]  sh_vis_q, sh_vis_d;
  logic [NUM_OBJ-1:0]  sh_blink_q, sh_blink_d;
  logic [ID_W-1:0]     act_layer_q [NUM_OBJ];
  logic [ID_W-1:0]     act_layer_d [NUM_OBJ];
  logic [NUM_OBJ-1:0]  act_vis_q, act_vis_d;
  logic [NUM_OBJ-1:0]  act_blink_q, act_blink_d;
  logic [BLINK_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                frame_coll_q, frame_coll_d;
  logic                coll_last_q, coll_last_d;
  logic [OFFSET_W-1:0] offset_x_q, offset_x_d;
  logic [OFFSET_W-1:0] offset_y_q, offset_y_d;
  logic [ID_W-1:0]     winner_q, winner_d;
  logic                draw_q, draw_d;
  logic                coll_q, coll_d;

  logic                cfg_fire;
  logic                blink_phase;
  logic [NUM_OBJ-1:0]  eligible;
  logic                found;
  logic                seen;
  logic [ID_W-1:0]     best_layer;

  assign cfg_ready   = !reset && !startOfFrame;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign blink_phase = frame_cnt_q[BLINK_W-1];

  // Shadow writes, commit to the active table, frame counter and sticky flags
  always_comb begin
    sh_layer_d  = sh_layer_q;
    sh_vis_d    = sh_vis_q;
    sh_blink_d  = sh_blink_q;
    act_layer_d = act_layer_q;
    act_vis_d   = act_vis_q;
    act_blink_d = act_blink_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (cfg_fire && cfg_obj == ID_W'(i)) begin
        sh_layer_d[i] = cfg_layer;
        sh_vis_d[i]   = cfg_visible;
        sh_blink_d[i] = cfg_blink;
      end
    end
    if (startOfFrame) begin
      act_layer_d = sh_layer_q;
      act_vis_d   = sh_vis_q;
      act_blink_d = sh_blink_q;
      frame_cnt_d = frame_cnt_q + BLINK_W'(1);
    end
  end

  // Arbitration; strict less-than keeps ties on the lowest index
  always_comb begin
    eligible   = '0;
    found      = 1'b0;
    seen       = 1'b0;
    best_layer = '0;
    winner_d   = '0;
    offset_x_d = '0;
    offset_y_d = '0;
    coll_d     = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      eligible[i] = drawRequest[i] && act_vis_q[i] && !(act_blink_q[i] && blink_phase);
      if (eligible[i]) begin
        if (seen) coll_d = 1'b1;
        seen = 1'b1;
        if (!found || act_layer_q[i] < best_layer) begin
          found      = 1'b1;
          best_layer = act_layer_q[i];
          winner_d   = ID_W'(i);
          offset_x_d = offsetX[i*OFFSET_W +: OFFSET_W];
          offset_y_d = offsetY[i*OFFSET_W +: OFFSET_W];
        end
      end
    end
    draw_d = found;
  end

  always_comb begin
    frame_coll_d = frame_coll_q | coll_d;
    coll_last_d  = coll_last_q;
    if (startOfFrame) begin
      coll_last_d  = frame_coll_q | coll_d;
      frame_coll_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_layer_q[i]  <= ID_W'(i);
        act_layer_q[i] <= ID_W'(i);
      end
      sh_vis_q     <= '1;
      sh_blink_q   <= '0;
      act_vis_q    <= '1;
      act_blink_q  <= '0;
      frame_cnt_q  <= '0;
      frame_coll_q <= 1'b0;
      coll_last_q  <= 1'b0;
      offset_x_q   <= '0;
      offset_y_q   <= '0;
      winner_q     <= '0;
      draw_q       <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      sh_layer_q   <= sh_layer_d;
      sh_vis_q     <= sh_vis_d;
      sh_blink_q   <= sh_blink_d;
      act_layer_q  <= act_layer_d;
      act_vis_q    <= act_vis_d;
      act_blink_q  <= act_blink_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_coll_q <= frame_coll_d;
      coll_last_q  <= coll_last_d;
      offset_x_q   <= offset_x_d;
      offset_y_q   <= offset_y_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
      coll_q       <= coll_d;
    end
  end

  assign offset_x             = offset_x_q;
  assign offset_y             = offset_y_q;
  assign drawRequestOut       = draw_q;
  assign winner_id            = winner_q;
  assign collision            = coll_q;
  assign collision_last_frame = coll_last_q;

endmodule

// File: doc/draw_layer_arbiter.md
# draw_layer_arbiter

Per-pixel draw arbiter for the VGA object pipeline. It takes draw requests and sprite offsets from up to NUM_OBJ object units and picks one winner per pixel from a per-object layer table. The table is software-configurable, double-buffered and committed at frame start. The block applies per-object visibility and frame-rate blinking, and reports overlaps. It sits between the object draw units and the bitmap/colour lookup stage, and replaces ad-hoc chains of two-input draw muxes.

## Interface
Parameters:
- NUM_OBJ, 4, number of requesters (2..8); ID_W = $clog2(NUM_OBJ), derived
- OFFSET_W, 11, width of each offset coordinate
- BLINK_W, 5, frame counter width; blink period is 2^BLINK_W frames

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high; overrides every other input
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- drawRequest  in  NUM_OBJ  bit i = object i requests this pixel
- offsetX  in  NUM_OBJ*OFFSET_W  object i X offset at bits [i*OFFSET_W +: OFFSET_W]
- offsetY  in  NUM_OBJ*OFFSET_W  object i Y offset, same packing
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
- cfg_obj  in  ID_W  object being configured
- cfg_layer  in  ID_W  layer; 0 = front
- cfg_visible  in  1  object enabled
- cfg_blink  in  1  object blinks
- offset_x  out  OFFSET_W  winner X offset
- offset_y  out  OFFSET_W  winner Y offset
- drawRequestOut  out  1  some eligible object won
- winner_id  out  ID_W  index of the winner
- collision  out  1  two or more eligible requests on this pixel
- collision_last_frame  out  1  a collision occurred during the previous frame

## Operation
- Config tables: two tables, shadow and active, each holding {layer, visible, blink} per object. Reset value of entry i in both tables is layer=i, visible=1, blink=0.
- Config writes: an accepted write updates shadow[cfg_obj] only.
- cfg_ready: equals !startOfFrame. It is 0 during reset.
- Commit: on startOfFrame, active <= shadow. A write held across the startOfFrame cycle is accepted on the next cycle and takes effect at the following startOfFrame.
- Frame counter: frame_cnt (BLINK_W bits) increments on every startOfFrame and wraps from 2^BLINK_W-1 to 0. blink_phase = frame_cnt[BLINK_W-1].
- Eligibility: eligible[i] = drawRequest[i] && active.visible[i] && !(active.blink[i] && blink_phase). Eligibility uses the active table and frame_cnt values before that cycle's update.
- Arbitration: the winner is the eligible object with the smallest layer value. Ties go to the lowest index.
- No eligible object: drawRequestOut=0, offset_x=0, offset_y=0, winner_id=0.
- collision: 1 when popcount(eligible) >= 2.
- Sticky collision: frame_coll is set by collision. On startOfFrame, collision_last_frame <= frame_coll | current collision, and frame_coll is cleared.

## Timing
- Reset values: all outputs 0 except cfg_ready, which is 0 during reset and 1 from the first cycle after reset deasserts. frame_cnt and frame_coll reset to 0.
- Latency: one registered stage. Inputs sampled at edge n appear on all arbitration outputs after edge n. offset_x, offset_y, winner_id, drawRequestOut and collision stay cycle-aligned.
- Commit point: the startOfFrame cycle's own arbitration still uses the old active table and the old blink phase. The new values apply from the next cycle.
- Reset mid-frame: tables, counter, sticky flag and outputs return to reset values in the next cycle. Any pending config is discarded.

## Test plan
- Reset, then drawRequest=4'b0110, offsetX1=11'd10, offsetX2=11'd20 -> one cycle later winner_id=1, offset_x=10, drawRequestOut=1, collision=1.
- Write obj3 layer=0, then drawRequest=4'b1010 -> before startOfFrame winner_id=1; from the cycle after startOfFrame winner_id=3.
- Set obj0 and obj2 both to layer=1 and commit; drawRequest=4'b0101 -> winner_id=0. Then set obj0 visible=0 and commit -> winner_id=2, collision=0.
- BLINK_W=2, obj0 blink=1, drawRequest=4'b0001 every frame -> drawRequestOut=1 in frames 0-1, 0 in frames 2-3, 1 again in frame 4 (wrap).
- Assert cfg_valid in the same cycle as startOfFrame -> cfg_ready=0; write accepted on the next cycle; effect visible only after the second startOfFrame.
- Overlap once in frame k -> collision_last_frame=1 throughout frame k+1. No overlap in frame k+1 -> collision_last_frame=0 in frame k+2. Reset mid-frame -> all outputs 0 on the next cycle.
